// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants and types for the four-digit seven-segment scan controller.
// Segment vectors are packed {g,f,e,d,c,b,a}.
package seven_seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Active-low anode pattern selecting a single digit.
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        logic [3:0] an;
        an      = AN_OFF;
        an[idx] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Bundle of the display-side signals: digit/control inputs and multiplexed
// anode/segment outputs.
interface seven_seg_scan_ctrl_if;
    logic        en;
    logic [15:0] BCD;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  an_n;
    logic        segA;
    logic        segB;
    logic        segC;
    logic        segD;
    logic        segE;
    logic        segF;
    logic        segG;
    logic        segDP;
    logic [1:0]  digit_idx;

    modport master (
        output en, BCD, dp_in, lz_blank,
        input  an_n, segA, segB, segC, segD, segE, segF, segG, segDP, digit_idx
    );

    modport slave (
        input  en, BCD, dp_in, lz_blank,
        output an_n, segA, segB, segC, segD, segE, segF, segG, segDP, digit_idx
    );
endinterface

// File: rtl/seven_seg_decoder.sv
// Combinational BCD-to-seven-segment decoder, active-high {g,f,e,d,c,b,a}.
// Codes above 9 decode to all-off; the caller applies its own override.
module seven_seg_decoder (
    input  logic [3:0] code,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b0000000;
        case (code)
            4'd0: seg = 7'b0111111;
            4'd1: seg = 7'b0000110;
            4'd2: seg = 7'b1011011;
            4'd3: seg = 7'b1001111;
            4'd4: seg = 7'b1100110;
            4'd5: seg = 7'b1101101;
            4'd6: seg = 7'b1111101;
            4'd7: seg = 7'b0000111;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
    end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed four-digit seven-segment scanner with anode guard blanking,
// per-slot digit latching, leading-zero blanking and dash display of codes 10..15.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    seven_seg_scan_ctrl_if.slave  bus
);

    localparam int              CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);

    scan_state_t      state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next, count_inc;
    logic [1:0]       digit_reg, digit_next;

    logic [3:0] code_reg;
    logic       dp_reg;
    logic [3:0] zero_mask_reg;

    logic [3:0] an_reg, an_next;
    logic [6:0] seg_reg, seg_next;
    logic       dpo_reg, dpo_next;
    logic [1:0] idx_reg, idx_next;

    logic [3:0] nibble [4];
    logic [3:0] lead_zero;
    logic [6:0] dec_seg;
    logic       digit_blanked;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nibble
            assign nibble[gi] = bus.BCD[4*gi +: 4];
        end
        // Digit k is a leading zero when it and every digit above it is zero.
        assign lead_zero[0] = 1'b0;
        for (gi = 1; gi < 4; gi++) begin : g_lead_zero
            assign lead_zero[gi] = ~|bus.BCD[15:4*gi];
        end
    endgenerate

    seven_seg_decoder u_dec (
        .code (code_reg),
        .seg  (dec_seg)
    );

    assign count_inc = count_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        digit_next = digit_reg;
        case (state_reg)
            ST_IDLE: begin
                count_next = '0;
                digit_next = 2'd0;
                if (bus.en) state_next = ST_BLANK;
            end
            ST_BLANK, ST_SHOW: begin
                if (count_reg == CNT_LAST) begin
                    count_next = '0;
                    digit_next = digit_reg + 2'd1;
                    state_next = ST_BLANK;
                end else begin
                    count_next = count_inc;
                    state_next = (count_inc >= CNT_SHOW) ? ST_SHOW : ST_BLANK;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
                digit_next = 2'd0;
            end
        endcase
        // Dropping enable aborts the scan from any state.
        if (!bus.en) begin
            state_next = ST_IDLE;
            count_next = '0;
            digit_next = 2'd0;
        end
    end

    assign digit_blanked = bus.lz_blank & zero_mask_reg[digit_reg];

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        dpo_next = 1'b0;
        idx_next = bus.en ? digit_reg : 2'd0;
        if (bus.en && state_reg == ST_SHOW && !digit_blanked) begin
            an_next  = anode_for(digit_reg);
            seg_next = (code_reg > 4'd9) ? SEG_DASH : dec_seg;
            dpo_next = dp_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            digit_reg     <= 2'd0;
            code_reg      <= 4'd0;
            dp_reg        <= 1'b0;
            zero_mask_reg <= 4'd0;
            an_reg        <= AN_OFF;
            seg_reg       <= SEG_OFF;
            dpo_reg       <= 1'b0;
            idx_reg       <= 2'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            digit_reg <= digit_next;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            dpo_reg   <= dpo_next;
            idx_reg   <= idx_next;
            // Snapshot the slot's digit at count 0; the leading-zero mask is
            // refreshed once per frame at the start of digit 0's slot.
            if (state_reg == ST_BLANK && count_reg == '0) begin
                code_reg <= nibble[digit_reg];
                dp_reg   <= bus.dp_in[digit_reg];
                if (digit_reg == 2'd0) zero_mask_reg <= lead_zero;
            end
        end
    end

    assign bus.an_n      = an_reg;
    assign bus.segA      = seg_reg[0];
    assign bus.segB      = seg_reg[1];
    assign bus.segC      = seg_reg[2];
    assign bus.segD      = seg_reg[3];
    assign bus.segE      = seg_reg[4];
    assign bus.segF      = seg_reg[5];
    assign bus.segG      = seg_reg[6];
    assign bus.segDP     = dpo_reg;
    assign bus.digit_idx = idx_reg;

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter BLANK_CYCLES, default 1000: anode-off guard cycles at the start of each slot; legal range 1..SCAN_DIV-2.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  scan enable; 0 = display dark.
REQ-006 BCD  input  16  four BCD digits; [3:0] = digit0 (rightmost), [15:12] = digit3.
REQ-007 dp_in  input  4  decimal-point request per digit; bit k = digit k.
REQ-008 lz_blank  input  1  leading-zero blanking enable.
REQ-009 an_n  output  4  digit anode enables, active-low; bit k = digit k.
REQ-010 segA..segG  output  1 each  segment drives, active-high.
REQ-011 segDP  output  1  decimal point, active-high.
REQ-012 digit_idx  output  2  index of the digit owning the current slot.

Function
REQ-013 FSM states: IDLE, BLANK, SHOW; the block SHALL drive exactly one shared decoder and time-multiplex it over the four digits.
REQ-014 IDLE: an_n=4'b1111, all segments 0, slot counter 0, digit_idx 0; exit to BLANK on the first clk with en=1.
REQ-015 Slot counter counts 0..SCAN_DIV-1 and wraps; state is BLANK for counts 0..BLANK_CYCLES-1 and SHOW for counts BLANK_CYCLES..SCAN_DIV-1.
REQ-016 On counter wrap, digit_idx increments modulo 4 (3 -> 0) and the state returns to BLANK.
REQ-017 In BLANK, an_n=4'b1111 and the segment outputs are 0.
REQ-018 On entry to BLANK (count 0), the block SHALL latch the 4-bit field and dp bit for digit_idx; SHOW displays only latched values, so BCD changes mid-slot never alter the display.
REQ-019 In SHOW, an_n has only bit digit_idx low, unless that digit is blanked (REQ-021), in which case an_n=4'b1111.
REQ-020 Latched codes 10..15: segments override to segG=1 only (dash); segDP still follows the latched dp bit.
REQ-021 With lz_blank=1, digit k (k=3,2,1) is blanked when digits k..3 are all 0, evaluated on the latched snapshot of the full BCD bus at count 0 of digit 0's slot; digit0 is never blanked; a blanked digit also suppresses its dp.
REQ-022 All outputs are registered; outputs reflect the state and count of the previous cycle (1-cycle latency).
REQ-023 When en falls, the next clk SHALL enter IDLE regardless of state (mid-slot abort); re-enable restarts at digit 0, count 0.
REQ-024 At most one an_n bit is low in any cycle; an_n transitions between two different digits SHALL always pass through at least BLANK_CYCLES cycles of 4'b1111.
REQ-025 The full refresh period is 4*SCAN_DIV cycles.

Reset
REQ-026 rst=1 on a clk edge SHALL force IDLE, counter 0, digit_idx 0, latched digit/dp 0, an_n=4'b1111, segA..segG=0, segDP=0, independent of en.
REQ-027 rst has priority over en; a rst asserted mid-SHOW darkens all outputs on the next edge.

Structure
REQ-028 A shared package (or include file) SHALL hold the FSM state encodings, the dash segment pattern and the anode-off constant 4'b1111.
REQ-029 The block SHALL instantiate one seven_seg_decoder sub-module for the BCD-to-segment mapping; scan, latching, blanking and dash override live in seven_seg_scan_ctrl.

Verification (SCAN_DIV=8, BLANK_CYCLES=2)
REQ-030 rst for 3 cycles, en=1, BCD=16'h1234 -> an_n cycles 1110/1101/1011/0111 in 6-cycle windows, each preceded by 2 cycles of 1111; segments show 4,3,2,1; period 32 cycles.
REQ-031 BCD=16'h0007, lz_blank=1 -> only an_n=1110 ever asserted, showing 7; with lz_blank=0 -> all four digits lit, showing 0,0,0,7.
REQ-032 BCD changes from 16'h1111 to 16'h9999 at count 4 of digit 1's slot -> digit 1 stays 1 until its slot ends; the next slots show 9.
REQ-033 Digit2 code = 4'hB, dp_in=4'b0100 -> during digit 2's SHOW only segG=1 and segDP=1.
REQ-034 en dropped at count 5 of digit 2's slot, raised 3 cycles later -> an_n=1111 the next cycle; the scan resumes at digit 0 with 2 blank cycles.
REQ-035 rst pulsed during SHOW -> all outputs 0/1111 the next cycle; an_n never has two low bits (assertion checked throughout).
